// File: rtl/ldu_stream_if.sv
// Command and pixel-stream bundle for the line drawer: a command handshake from
// the GPU decoder and a valid/ready pixel stream towards the framebuffer port.
`timescale 1ns/1ps
interface ldu_stream_if #(parameter int COORD_W = 7);
  logic               start;
  logic               cmd_ready;
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               abort;
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] xOut;
  logic [COORD_W-1:0] yOut;
  logic               pix_last;
  logic               is_drawing;
  logic               done;

  modport master (
    output start, x0, y0, x1, y1, abort, pix_ready,
    input  cmd_ready, pix_valid, xOut, yOut, pix_last, is_drawing, done
  );

  modport slave (
    input  start, x0, y0, x1, y1, abort, pix_ready,
    output cmd_ready, pix_valid, xOut, yOut, pix_last, is_drawing, done
  );
endinterface

// File: rtl/ldu_stream.sv
// Bresenham line rasteriser for all octants: one segment per command,
// streamed out one pixel per accepted handshake, with last-pixel flag and done pulse.
`timescale 1ns/1ps
module ldu_stream #(
  parameter int COORD_W = 7
) (
  input logic         clk,
  input logic         reset,
  ldu_stream_if.slave bus
);
  localparam int EW = COORD_W + 3;
  localparam logic [COORD_W-1:0]   ONE_C  = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] ZERO_E = {EW{1'b0}};

  typedef enum logic [0:0] {IDLE = 1'b0, DRAW = 1'b1} state_t;

  state_t                state_r, state_s;
  logic [COORD_W-1:0]    x_r, y_r, x1_r, y1_r;
  logic [COORD_W-1:0]    x_s, y_s, x1_s, y1_s;
  logic signed [EW-1:0]  dx_r, dy_r, err_r;
  logic signed [EW-1:0]  dx_s, dy_s, err_s;
  logic                  sx_r, sy_r, sx_s, sy_s;
  logic                  pix_last_r, pix_last_s;
  logic                  done_r, done_s;

  logic [COORD_W-1:0]    abs_dx_s, abs_dy_s;
  logic signed [EW-1:0]  start_dx_s, start_dy_s;
  logic signed [EW-1:0]  e2_s, err_step_s;
  logic                  step_x_s, step_y_s;
  logic [COORD_W-1:0]    x_nx_s, y_nx_s;

  // Command-time terms: dx is non-negative, dy is stored negated as Bresenham expects
  assign abs_dx_s   = (bus.x1 >= bus.x0) ? (bus.x1 - bus.x0) : (bus.x0 - bus.x1);
  assign abs_dy_s   = (bus.y1 >= bus.y0) ? (bus.y1 - bus.y0) : (bus.y0 - bus.y1);
  assign start_dx_s = signed'({3'b000, abs_dx_s});
  assign start_dy_s = -signed'({3'b000, abs_dy_s});

  // Both step decisions use the same e2 taken from the pre-step error
  assign e2_s       = err_r <<< 1;
  assign step_x_s   = (e2_s >= dy_r);
  assign step_y_s   = (e2_s <= dx_r);
  assign err_step_s = err_r + (step_x_s ? dy_r : ZERO_E) + (step_y_s ? dx_r : ZERO_E);
  assign x_nx_s     = step_x_s ? (sx_r ? (x_r + ONE_C) : (x_r - ONE_C)) : x_r;
  assign y_nx_s     = step_y_s ? (sy_r ? (y_r + ONE_C) : (y_r - ONE_C)) : y_r;

  // Next-state and datapath update
  always_comb begin
    state_s    = state_r;
    x_s        = x_r;
    y_s        = y_r;
    x1_s       = x1_r;
    y1_s       = y1_r;
    dx_s       = dx_r;
    dy_s       = dy_r;
    err_s      = err_r;
    sx_s       = sx_r;
    sy_s       = sy_r;
    pix_last_s = pix_last_r;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s    = DRAW;
          x_s        = bus.x0;
          y_s        = bus.y0;
          x1_s       = bus.x1;
          y1_s       = bus.y1;
          dx_s       = start_dx_s;
          dy_s       = start_dy_s;
          err_s      = start_dx_s + start_dy_s;
          sx_s       = (bus.x0 < bus.x1);
          sy_s       = (bus.y0 < bus.y1);
          pix_last_s = (bus.x0 == bus.x1) && (bus.y0 == bus.y1);
        end else begin
          state_s = IDLE;
        end
      end
      DRAW: begin
        if (bus.abort) begin
          state_s    = IDLE;
          pix_last_s = 1'b0;
        end else if (bus.pix_ready) begin
          if (pix_last_r) begin
            state_s    = IDLE;
            pix_last_s = 1'b0;
            done_s     = 1'b1;
          end else begin
            x_s        = x_nx_s;
            y_s        = y_nx_s;
            err_s      = err_step_s;
            pix_last_s = (x_nx_s == x1_r) && (y_nx_s == y1_r);
          end
        end else begin
          state_s = DRAW;
        end
      end
      default: begin
        state_s    = IDLE;
        pix_last_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      x_r        <= {COORD_W{1'b0}};
      y_r        <= {COORD_W{1'b0}};
      x1_r       <= {COORD_W{1'b0}};
      y1_r       <= {COORD_W{1'b0}};
      dx_r       <= ZERO_E;
      dy_r       <= ZERO_E;
      err_r      <= ZERO_E;
      sx_r       <= 1'b0;
      sy_r       <= 1'b0;
      pix_last_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      x_r        <= x_s;
      y_r        <= y_s;
      x1_r       <= x1_s;
      y1_r       <= y1_s;
      dx_r       <= dx_s;
      dy_r       <= dy_s;
      err_r      <= err_s;
      sx_r       <= sx_s;
      sy_r       <= sy_s;
      pix_last_r <= pix_last_s;
      done_r     <= done_s;
    end
  end

  assign bus.cmd_ready  = (state_r == IDLE);
  assign bus.pix_valid  = (state_r == DRAW);
  assign bus.is_drawing = (state_r == DRAW);
  assign bus.xOut       = x_r;
  assign bus.yOut       = y_r;
  assign bus.pix_last   = pix_last_r;
  assign bus.done       = done_r;
endmodule

// File: tb/tb_ldu_stream.sv
// Directed bench for ldu_stream: a Bresenham reference fills a pixel scoreboard
// at command time; accepted pixels are popped and compared.
`timescale 1ns/1ps
module tb_ldu_stream;
  localparam int W = 7;

  typedef struct {
    int x;
    int y;
    bit last;
  } pix_t;

  logic clk = 1'b0;
  logic reset;
  pix_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ldu_stream_if #(.COORD_W(W)) bus ();
  ldu_stream #(.COORD_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input int ax0, input int ay0, input int ax1, input int ay1);
    int dx, dy, sx, sy, err, e2, x, y;
    pix_t p;
    dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy  = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx  = (ax0 < ax1) ? 1 : -1;
    sy  = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    x   = ax0;
    y   = ay0;
    for (int i = 0; i < 400; i++) begin
      p.x = x; p.y = y; p.last = (x == ax1) && (y == ay1);
      exp_q.push_back(p);
      if (p.last) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  task automatic drive_start(input int ax0, input int ay0, input int ax1, input int ay1);
    bus.start = 1'b1;
    bus.x0 = ax0[W-1:0];
    bus.y0 = ay0[W-1:0];
    bus.x1 = ax1[W-1:0];
    bus.y1 = ay1[W-1:0];
  endtask

  // mode 0: pix_ready always 1; mode 1: ready one cycle in three
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int mode, input bit abort_at_start, input bit busy_start,
                          input bit chain, input string tag);
    int n, c, acc;
    bit fin, stalled, rdy;
    logic [W-1:0] px, py;
    logic pl;
    pix_t e;
    exp_q.delete();
    model(ax0, ay0, ax1, ay1);
    n = exp_q.size();
    drive_start(ax0, ay0, ax1, ay1);
    bus.abort = abort_at_start;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    c = 1; acc = 0; fin = 1'b0; stalled = 1'b0;
    px = '0; py = '0; pl = 1'b0;
    while (!fin && c < 1000) begin
      rdy = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      bus.pix_ready = rdy;
      if (busy_start && c == 3) drive_start(100, 100, 0, 0);
      else bus.start = 1'b0;
      chk({tag, "_valid"}, bus.pix_valid, 1);
      chk({tag, "_drawing"}, bus.is_drawing, 1);
      chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
      if (stalled) begin
        chk({tag, "_hold_x"}, bus.xOut, px);
        chk({tag, "_hold_y"}, bus.yOut, py);
        chk({tag, "_hold_last"}, bus.pix_last, pl);
      end
      if (rdy) begin
        if (exp_q.size() == 0) begin
          chk({tag, "_extra_pixel"}, 1, 0);
          fin = 1'b1;
        end else begin
          e = exp_q.pop_front();
          chk({tag, "_x"}, bus.xOut, e.x);
          chk({tag, "_y"}, bus.yOut, e.y);
          chk({tag, "_last"}, bus.pix_last, e.last);
          acc++;
          if (e.last) fin = 1'b1;
        end
      end
      px = bus.xOut; py = bus.yOut; pl = bus.pix_last;
      stalled = !rdy;
      tick();
      c++;
    end
    bus.start = 1'b0;
    bus.pix_ready = 1'b1;
    chk({tag, "_timeout"}, fin, 1);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_valid_after"}, bus.pix_valid, 0);
    chk({tag, "_cmd_ready_after"}, bus.cmd_ready, 1);
    chk({tag, "_count"}, acc, n);
    if (mode == 0) chk({tag, "_done_cycle"}, c, n + 1);
    if (!chain) begin
      tick();
      chk({tag, "_done_pulse"}, bus.done, 0);
    end
  endtask

  task automatic cut_line(input bit use_reset, input string tag);
    int c, acc;
    pix_t e;
    exp_q.delete();
    model(0, 0, 20, 0);
    drive_start(0, 0, 20, 0);
    bus.pix_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    c = 0; acc = 0;
    while (acc < 5 && c < 100) begin
      e = exp_q.pop_front();
      chk({tag, "_x"}, bus.xOut, e.x);
      chk({tag, "_y"}, bus.yOut, e.y);
      acc++;
      c++;
      tick();
    end
    bus.pix_ready = 1'b0;
    if (use_reset) reset = 1'b1;
    else bus.abort = 1'b1;
    tick();
    reset = 1'b0;
    bus.abort = 1'b0;
    chk({tag, "_valid"}, bus.pix_valid, 0);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_drawing"}, bus.is_drawing, 0);
    chk({tag, "_last"}, bus.pix_last, 0);
    if (use_reset) begin
      chk({tag, "_xout"}, bus.xOut, 0);
      chk({tag, "_yout"}, bus.yOut, 0);
    end
    tick();
    chk({tag, "_done_late"}, bus.done, 0);
    chk({tag, "_valid_late"}, bus.pix_valid, 0);
    bus.pix_ready = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.pix_ready = 1'b1;
    bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
    tick();
    tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_valid", bus.pix_valid, 0);
    chk("rst_last", bus.pix_last, 0);
    chk("rst_drawing", bus.is_drawing, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_xout", bus.xOut, 0);
    chk("rst_yout", bus.yOut, 0);
    reset = 1'b0;
    tick();

    run_line(63, 31, 0, 0, 0, 1'b0, 1'b0, 1'b0, "diag");
    run_line(5, 0, 5, 9, 0, 1'b0, 1'b0, 1'b1, "vert");
    run_line(0, 0, 3, 10, 0, 1'b0, 1'b1, 1'b0, "steep");

    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("idle_abort_ready", bus.cmd_ready, 1);
    chk("idle_abort_valid", bus.pix_valid, 0);
    run_line(12, 12, 12, 12, 0, 1'b1, 1'b0, 1'b0, "point");

    run_line(0, 0, 9, 4, 1, 1'b0, 1'b0, 1'b0, "stall");

    cut_line(1'b0, "abort");
    run_line(2, 3, 6, 1, 0, 1'b0, 1'b0, 1'b0, "after_abort");
    cut_line(1'b1, "reset");
    run_line(40, 10, 30, 17, 0, 1'b0, 1'b0, 1'b0, "after_reset");

    run_line(0, 127, 127, 127, 0, 1'b0, 1'b0, 1'b0, "top_row");
    run_line(127, 0, 0, 127, 0, 1'b0, 1'b0, 1'b0, "anti_diag");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ldu_stream.md
Name: ldu_stream

Overview:
- Parametrised successor to the GPU line drawer unit: rasterises one line segment per command with integer Bresenham, all octants.
- Generalised coordinate width.
- Adds a command handshake, a pixel stream with backpressure, last-pixel marking, a done pulse and abort.
- Sits between the GPU command decoder and the framebuffer write port.

Parameters:
- COORD_W, 7, width of each coordinate in bits (unsigned, 0 .. 2^COORD_W-1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  command valid
- cmd_ready  out  1  block idle, can accept a command
- x0  in  COORD_W  start x
- y0  in  COORD_W  start y
- x1  in  COORD_W  end x
- y1  in  COORD_W  end y
- abort  in  1  synchronous cancel of the current line
- pix_valid  out  1  xOut/yOut hold a valid pixel
- pix_ready  in  1  consumer accepts the pixel
- xOut  out  COORD_W  pixel x
- yOut  out  COORD_W  pixel y
- pix_last  out  1  current pixel is (x1,y1)
- is_drawing  out  1  high while in DRAW state
- done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (synchronous, active-high, has priority over everything):
  - State goes to IDLE.
  - Output values: cmd_ready=1, pix_valid=0, pix_last=0, is_drawing=0, done=0, xOut=0, yOut=0.
  - Reset during DRAW discards the line. No done pulse.
- States: IDLE, DRAW.
- IDLE:
  - cmd_ready=1.
  - start=1 at edge k latches x0,y0,x1,y1 and computes the Bresenham terms:
    - dx=|x1-x0|
    - dy=-|y1-y0|
    - sx=+1 if x0<x1, else -1
    - sy=+1 if y0<y1, else -1
    - err=dx+dy
  - The block enters DRAW with xOut=x0, yOut=y0 and pix_valid=1 in cycle k+1.
  - start while cmd_ready=0 is ignored.
- DRAW:
  - is_drawing=1, cmd_ready=0.
  - On a handshake (pix_valid & pix_ready) that is not the last pixel, compute e2=2*err, then:
    - if e2>=dy: err+=dy, x+=sx
    - if e2<=dx: err+=dx, y+=sy
  - The next pixel is presented in the following cycle. At most one pixel is emitted per cycle.
- Backpressure: while pix_ready=0, xOut, yOut, pix_valid and pix_last hold stable.
- pix_last=1 exactly when (xOut,yOut)==(x1,y1).
- Handshake on the last pixel:
  - Next cycle: done=1 for one cycle, state IDLE, cmd_ready=1, pix_valid=0.
  - A start in that done cycle is accepted.
- Pixel count per line = max(dx,|dy|)+1. Latency with pix_ready held 1:
  - First pixel in cycle k+1.
  - Last pixel in cycle k+N.
  - done in cycle k+N+1.
- Degenerate line (x0,y0)==(x1,y1): exactly one pixel, with pix_last=1.
- Arithmetic:
  - err and e2 are signed, COORD_W+3 bits. No overflow for any coordinates.
  - Working x/y never leave [0, 2^COORD_W-1]. No wrap-around.
- abort=1 in DRAW:
  - Next cycle: IDLE, pix_valid=0, pix_last=0, cmd_ready=1. No done pulse.
  - If abort coincides with a handshake, the accepted pixel counts as consumed but is not followed by done.
- abort in IDLE has no effect.
- abort and start in the same IDLE cycle: start is accepted.

Test Plan:
- COORD_W=7, (63,31)->(0,0), pix_ready=1:
  - 64 pixels, first (63,31), last (0,0) with pix_last=1.
  - x decrements every pixel, y decrements on 31 of 63 steps.
  - done exactly 65 cycles after the start edge.
- (5,0)->(5,9):
  - 10 pixels, xOut=5 throughout, y=0..9.
  - Steep octant (0,0)->(3,10): 11 pixels, each step |Δx|≤1 and |Δy|=1, last (3,10).
- (12,12)->(12,12): single pixel (12,12) with pix_last=1 in cycle k+1, done in k+2.
- (0,0)->(9,4) with pix_ready toggling in a 1-of-3 pattern:
  - Outputs held stable while stalled.
  - Exactly 10 unique pixels accepted, sequence identical to the pix_ready=1 run.
- Abort and reset mid-line:
  - Abort after the 5th accepted pixel of (0,0)->(20,0): pix_valid=0 and cmd_ready=1 next cycle, no done.
  - A new start is then accepted.
  - Reset mid-line gives the same result, with all outputs at reset values.
- COORD_W=7, (0,127)->(127,127) and (127,0)->(0,127):
  - 128 pixels each, no wrap.
  - Second line ends at (0,127) with the diagonal (x+y==127) maintained.
